// File: rtl/ram_pkg.sv
// Shared definitions for the dual-port byte-enable RAM: read-during-write modes,
// address index sizing and byte-lane merging.
package ram_pkg;

    typedef enum logic [1:0] {
        RDW_READ_FIRST  = 2'd0,
        RDW_WRITE_FIRST = 2'd1,
        RDW_NO_CHANGE   = 2'd2
    } rdw_mode_e;

    // Widest word the merge helper handles; callers size-cast in and out.
    localparam int unsigned MERGE_MAX_W  = 1024;
    localparam int unsigned MERGE_MAX_BE = MERGE_MAX_W / 8;

    function automatic int unsigned idx_width(input int unsigned words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

    function automatic logic [MERGE_MAX_W-1:0] merge_bytes(
        input logic [MERGE_MAX_W-1:0]  old_w,
        input logic [MERGE_MAX_W-1:0]  new_w,
        input logic [MERGE_MAX_BE-1:0] be
    );
        logic [MERGE_MAX_W-1:0] res;
        res = old_w;
        for (int unsigned k = 0; k < MERGE_MAX_BE; k++) begin
            if (be[k]) res[8*k +: 8] = new_w[8*k +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/ram_port_rsp.sv
// Per-port response path: read-during-write data select, valid pipeline and
// optional second output register stage.
module ram_port_rsp
    import ram_pkg::*;
#(
    parameter int unsigned dat_width = 32,
    parameter int unsigned rdw_mode  = 0,
    parameter int unsigned out_reg   = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_i,
    input  logic                 we_i,
    input  logic [dat_width-1:0] old_i,
    input  logic [dat_width-1:0] new_i,
    output logic                 rvalid_o,
    output logic [dat_width-1:0] dat_o
);

    localparam rdw_mode_e MODE = rdw_mode_e'(rdw_mode[1:0]);

    logic                 s1_vld_d, s1_vld_q;
    logic [dat_width-1:0] s1_dat_d, s1_dat_q;

    always_comb begin
        s1_vld_d = req_i;
        s1_dat_d = s1_dat_q;
        if (req_i) begin
            if (!we_i) begin
                s1_dat_d = old_i;
            end else begin
                case (MODE)
                    RDW_READ_FIRST:  s1_dat_d = old_i;
                    RDW_WRITE_FIRST: s1_dat_d = new_i;
                    default:         s1_dat_d = s1_dat_q;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld_q <= 1'b0;
            s1_dat_q <= '0;
        end else begin
            s1_vld_q <= s1_vld_d;
            s1_dat_q <= s1_dat_d;
        end
    end

    if (out_reg != 0) begin : g_out_reg
        logic                 s2_vld_d, s2_vld_q;
        logic [dat_width-1:0] s2_dat_d, s2_dat_q;

        // Stage 2 only reloads on a stage-1 response, so NO_CHANGE holds here too.
        always_comb begin
            s2_vld_d = s1_vld_q;
            s2_dat_d = s1_vld_q ? s1_dat_q : s2_dat_q;
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                s2_vld_q <= 1'b0;
                s2_dat_q <= '0;
            end else begin
                s2_vld_q <= s2_vld_d;
                s2_dat_q <= s2_dat_d;
            end
        end

        assign rvalid_o = s2_vld_q;
        assign dat_o    = s2_dat_q;
    end else begin : g_no_out_reg
        assign rvalid_o = s1_vld_q;
        assign dat_o    = s1_dat_q;
    end

endmodule

// File: rtl/ram_dp_be.sv
// True dual-port synchronous RAM with per-byte write enables, selectable
// read-during-write behaviour and fixed-latency response handshake per port.
module ram_dp_be
    import ram_pkg::*;
#(
    parameter int unsigned dat_width = 32,
    parameter int unsigned adr_width = 32,
    parameter int unsigned mem_size  = 1024,
    parameter int unsigned rdw_mode  = 0,
    parameter int unsigned out_reg   = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   a_req_i,
    input  logic                   a_we_i,
    input  logic [dat_width/8-1:0] a_be_i,
    input  logic [adr_width-1:0]   a_adr_i,
    input  logic [dat_width-1:0]   a_dat_i,
    output logic                   a_rvalid_o,
    output logic [dat_width-1:0]   a_dat_o,
    input  logic                   b_req_i,
    input  logic                   b_we_i,
    input  logic [dat_width/8-1:0] b_be_i,
    input  logic [adr_width-1:0]   b_adr_i,
    input  logic [dat_width-1:0]   b_dat_i,
    output logic                   b_rvalid_o,
    output logic [dat_width-1:0]   b_dat_o
);

    localparam int unsigned AW = idx_width(mem_size);
    localparam int unsigned BW = dat_width / 8;

    if ((dat_width % 8) != 0 || dat_width == 0 || dat_width > MERGE_MAX_W) begin : g_bad_dat_width
        $error("ram_dp_be: dat_width=%0d must be a non-zero multiple of 8 up to %0d", dat_width, MERGE_MAX_W);
    end
    if (mem_size == 0 || (mem_size & (mem_size - 1)) != 0) begin : g_bad_mem_size
        $error("ram_dp_be: mem_size=%0d must be a power of two", mem_size);
    end
    if (adr_width < AW) begin : g_bad_adr_width
        $error("ram_dp_be: adr_width=%0d too narrow for mem_size=%0d", adr_width, mem_size);
    end
    if (rdw_mode > 2) begin : g_bad_rdw_mode
        $error("ram_dp_be: rdw_mode=%0d out of range", rdw_mode);
    end

    // Upper address bits are deliberately ignored so addresses wrap.
    if (adr_width > AW) begin : g_adr_upper
        logic unused_adr_bits;
        assign unused_adr_bits = ^{a_adr_i[adr_width-1:AW], b_adr_i[adr_width-1:AW]};
    end

    logic [dat_width-1:0] mem_q [mem_size];
    logic [AW-1:0]        a_idx, b_idx;
    logic                 a_wr, b_wr;
    logic [dat_width-1:0] a_old, b_old, a_new, b_new;

    always_comb begin
        a_idx = a_adr_i[AW-1:0];
        b_idx = b_adr_i[AW-1:0];
        a_wr  = a_req_i & a_we_i;
        b_wr  = b_req_i & b_we_i;
        a_old = mem_q[a_idx];
        b_old = mem_q[b_idx];
        a_new = dat_width'(merge_bytes(MERGE_MAX_W'(a_old), MERGE_MAX_W'(a_dat_i), MERGE_MAX_BE'(a_be_i)));
        b_new = dat_width'(merge_bytes(MERGE_MAX_W'(b_old), MERGE_MAX_W'(b_dat_i), MERGE_MAX_BE'(b_be_i)));
    end

    // Port B lanes are scheduled first so port A overrides any shared byte.
    always_ff @(posedge clk) begin
        for (int unsigned k = 0; k < BW; k++) begin
            if (b_wr && b_be_i[k]) mem_q[b_idx][8*k +: 8] <= b_dat_i[8*k +: 8];
            if (a_wr && a_be_i[k]) mem_q[a_idx][8*k +: 8] <= a_dat_i[8*k +: 8];
        end
    end

    ram_port_rsp #(
        .dat_width (dat_width),
        .rdw_mode  (rdw_mode),
        .out_reg   (out_reg)
    ) u_rsp_a (
        .clk      (clk),
        .rst      (rst),
        .req_i    (a_req_i),
        .we_i     (a_we_i),
        .old_i    (a_old),
        .new_i    (a_new),
        .rvalid_o (a_rvalid_o),
        .dat_o    (a_dat_o)
    );

    ram_port_rsp #(
        .dat_width (dat_width),
        .rdw_mode  (rdw_mode),
        .out_reg   (out_reg)
    ) u_rsp_b (
        .clk      (clk),
        .rst      (rst),
        .req_i    (b_req_i),
        .we_i     (b_we_i),
        .old_i    (b_old),
        .new_i    (b_new),
        .rvalid_o (b_rvalid_o),
        .dat_o    (b_dat_o)
    );

endmodule

// File: tb/tb_ram_dp_be.sv
// Four RAM instances (READ_FIRST, WRITE_FIRST, NO_CHANGE, READ_FIRST+out_reg)
// share one stimulus stream; a behavioural model feeds per-port scoreboards.
module tb_ram_dp_be;

    localparam int NI = 4;

    typedef struct {
        logic [31:0] dat;
        int unsigned cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_req, a_we, b_req, b_we;
    logic [3:0]  a_be, b_be;
    logic [31:0] a_adr, b_adr, a_din, b_din;
    logic        a_rv [NI];
    logic        b_rv [NI];
    logic [31:0] a_do [NI];
    logic [31:0] b_do [NI];

    int unsigned mode_of [NI] = '{0, 1, 2, 0};
    int unsigned lat_of  [NI] = '{1, 1, 1, 2};

    logic [31:0] mdl [1024];
    logic [31:0] last [NI][2];
    exp_t        sb [2*NI][$];
    int unsigned cyc;
    int          n_chk;
    int          n_fail;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        ram_dp_be #(
            .dat_width (32),
            .adr_width (32),
            .mem_size  (1024),
            .rdw_mode  ((g == 3) ? 0 : g),
            .out_reg   ((g == 3) ? 1 : 0)
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .a_req_i    (a_req),
            .a_we_i     (a_we),
            .a_be_i     (a_be),
            .a_adr_i    (a_adr),
            .a_dat_i    (a_din),
            .a_rvalid_o (a_rv[g]),
            .a_dat_o    (a_do[g]),
            .b_req_i    (b_req),
            .b_we_i     (b_we),
            .b_be_i     (b_be),
            .b_adr_i    (b_adr),
            .b_dat_i    (b_din),
            .b_rvalid_o (b_rv[g]),
            .b_dat_o    (b_do[g])
        );
    end

    function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
        logic [31:0] r;
        r = o;
        for (int k = 0; k < 4; k++) begin
            if (be[k]) r[8*k +: 8] = n[8*k +: 8];
        end
        return r;
    endfunction

    function automatic logic [31:0] rsp_of(input int unsigned mode, input logic we,
                                           input logic [31:0] o, input logic [31:0] n, input logic [31:0] prev);
        if (!we) return o;
        case (mode)
            0:       return o;
            1:       return n;
            default: return prev;
        endcase
    endfunction

    task automatic drive(input logic ar, input logic aw, input logic [3:0] abe, input logic [31:0] aadr, input logic [31:0] adat,
                         input logic br, input logic bw, input logic [3:0] bbe, input logic [31:0] badr, input logic [31:0] bdat);
        logic [31:0] ao, bo, an, bn, r;
        exp_t        e;
        a_req = ar; a_we = aw; a_be = abe; a_adr = aadr; a_din = adat;
        b_req = br; b_we = bw; b_be = bbe; b_adr = badr; b_din = bdat;
        ao = mdl[aadr[9:0]];
        bo = mdl[badr[9:0]];
        an = bmerge(ao, adat, abe);
        bn = bmerge(bo, bdat, bbe);
        for (int i = 0; i < NI; i++) begin
            if (ar) begin
                r = rsp_of(mode_of[i], aw, ao, an, last[i][0]);
                last[i][0] = r;
                e.dat = r; e.cyc = cyc + lat_of[i];
                sb[2*i].push_back(e);
            end
            if (br) begin
                r = rsp_of(mode_of[i], bw, bo, bn, last[i][1]);
                last[i][1] = r;
                e.dat = r; e.cyc = cyc + lat_of[i];
                sb[2*i+1].push_back(e);
            end
        end
        if (br && bw) mdl[badr[9:0]] = bmerge(mdl[badr[9:0]], bdat, bbe);
        if (ar && aw) mdl[aadr[9:0]] = bmerge(mdl[aadr[9:0]], adat, abe);
    endtask

    task automatic monitor();
        logic        rv;
        logic [31:0] d;
        for (int k = 0; k < 2*NI; k++) begin
            rv = (k % 2 == 0) ? a_rv[k/2] : b_rv[k/2];
            d  = (k % 2 == 0) ? a_do[k/2] : b_do[k/2];
            n_chk++;
            if (sb[k].size() > 0 && sb[k][0].cyc == cyc) begin
                if (rv !== 1'b1 || d !== sb[k][0].dat) begin
                    n_fail++;
                    $display("FAIL rsp inst%0d port%0d cyc%0d: rvalid=%b dat=%h, required rvalid=1 dat=%h",
                             k/2, k%2, cyc, rv, d, sb[k][0].dat);
                end
                void'(sb[k].pop_front());
            end else if (rv !== 1'b0) begin
                n_fail++;
                $display("FAIL idle inst%0d port%0d cyc%0d: rvalid=%b, required 0", k/2, k%2, cyc, rv);
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        monitor();
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            drive('0, '0, '0, '0, '0, '0, '0, '0, '0, '0);
            cycle();
        end
    endtask

    task automatic check_zero(input string tag);
        for (int i = 0; i < NI; i++) begin
            n_chk++;
            if (a_rv[i] !== 1'b0 || a_do[i] !== 32'h0 || b_rv[i] !== 1'b0 || b_do[i] !== 32'h0) begin
                n_fail++;
                $display("FAIL %s inst%0d: a_rv=%b a_do=%h b_rv=%b b_do=%h, required all 0",
                         tag, i, a_rv[i], a_do[i], b_rv[i], b_do[i]);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive('0, '0, '0, '0, '0, '0, '0, '0, '0, '0);
        cycle();
        cycle();
        check_zero("reset_state");
        rst = 1'b0;
        idle(2);
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 1'b1, 4'hF, 32'd9, 32'h5A5A5A5A, '0, '0, '0, '0, '0);
        cycle();
        drive(1'b1, 1'b0, '0, 32'd9, '0, '0, '0, '0, '0, '0);
        cycle();
        drive('0, '0, '0, '0, '0, '0, '0, '0, '0, '0);
        #2 rst = 1'b1;
        #1 check_zero("reset_async");
        for (int k = 0; k < 2*NI; k++) sb[k].delete();
        for (int i = 0; i < NI; i++) begin
            last[i][0] = '0;
            last[i][1] = '0;
        end
        cycle();
        rst = 1'b0;
        idle(3);
    endtask

    task automatic test_byte_enable();
        drive(1'b1, 1'b1, 4'hF, 32'd5, 32'hFFFFFFFF, '0, '0, '0, '0, '0);
        cycle();
        drive(1'b1, 1'b1, 4'b0101, 32'd5, 32'h12345678, '0, '0, '0, '0, '0);
        cycle();
        drive(1'b1, 1'b0, '0, 32'd5, '0, '0, '0, '0, '0, '0);
        cycle();
        n_chk++;
        if (a_rv[0] !== 1'b1 || a_do[0] !== 32'hFF34FF78) begin
            n_fail++;
            $display("FAIL byte_merge: rvalid=%b dat=%h, required 1/ff34ff78", a_rv[0], a_do[0]);
        end
        drive(1'b1, 1'b1, 4'h0, 32'd5, 32'h0, '0, '0, '0, '0, '0);
        cycle();
        drive('0, '0, '0, '0, '0, 1'b1, 1'b0, '0, 32'd5, '0);
        cycle();
        n_chk++;
        if (b_rv[0] !== 1'b1 || b_do[0] !== 32'hFF34FF78) begin
            n_fail++;
            $display("FAIL be_zero_noop: rvalid=%b dat=%h, required 1/ff34ff78", b_rv[0], b_do[0]);
        end
        idle(2);
    endtask

    task automatic test_rdw_modes();
        logic [31:0] req_dat [3];
        req_dat[0] = 32'hAAAA0000;
        req_dat[1] = 32'h0000BBBB;
        req_dat[2] = 32'hFF34FF78;
        drive(1'b1, 1'b1, 4'hF, 32'd7, 32'hAAAA0000, '0, '0, '0, '0, '0);
        cycle();
        drive(1'b1, 1'b0, '0, 32'd5, '0, '0, '0, '0, '0, '0);
        cycle();
        drive(1'b1, 1'b1, 4'hF, 32'd7, 32'h0000BBBB, '0, '0, '0, '0, '0);
        cycle();
        for (int i = 0; i < 3; i++) begin
            n_chk++;
            if (a_rv[i] !== 1'b1 || a_do[i] !== req_dat[i]) begin
                n_fail++;
                $display("FAIL rdw_mode%0d: rvalid=%b dat=%h, required 1/%h", i, a_rv[i], a_do[i], req_dat[i]);
            end
        end
        idle(2);
    endtask

    task automatic test_collision();
        drive(1'b1, 1'b1, 4'hF, 32'd3, 32'h0, 1'b1, 1'b1, 4'hF, 32'd4, 32'h0);
        cycle();
        drive(1'b1, 1'b1, 4'b0011, 32'd3, 32'h11111111, 1'b1, 1'b1, 4'b0110, 32'd3, 32'h22222222);
        cycle();
        drive(1'b1, 1'b0, '0, 32'd3, '0, '0, '0, '0, '0, '0);
        cycle();
        n_chk++;
        if (a_do[0] !== 32'h00221111) begin
            n_fail++;
            $display("FAIL collision_ww: dat=%h, required 00221111", a_do[0]);
        end
        drive(1'b1, 1'b1, 4'hF, 32'd4, 32'hCAFEF00D, 1'b1, 1'b0, '0, 32'd4, '0);
        cycle();
        for (int i = 0; i < 3; i++) begin
            n_chk++;
            if (b_rv[i] !== 1'b1 || b_do[i] !== 32'h0) begin
                n_fail++;
                $display("FAIL collision_wr inst%0d: rvalid=%b dat=%h, required 1/00000000", i, b_rv[i], b_do[i]);
            end
        end
        idle(2);
    endtask

    task automatic test_wrap();
        drive(1'b1, 1'b1, 4'hF, 32'h400, 32'hDEADBEEF, '0, '0, '0, '0, '0);
        cycle();
        drive('0, '0, '0, '0, '0, 1'b1, 1'b0, '0, 32'h0, '0);
        cycle();
        n_chk++;
        if (b_rv[3] !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_early: rvalid=%b, required 0", b_rv[3]);
        end
        drive('0, '0, '0, '0, '0, '0, '0, '0, '0, '0);
        cycle();
        n_chk++;
        if (b_rv[3] !== 1'b1 || b_do[3] !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL wrap_outreg: rvalid=%b dat=%h, required 1/deadbeef", b_rv[3], b_do[3]);
        end
        idle(2);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 16; i += 2) begin
            drive(1'b1, 1'b1, 4'hF, i, i*3, 1'b1, 1'b1, 4'hF, i+1, (i+1)*3);
            cycle();
        end
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b0, '0, i, '0, 1'b1, 1'b0, '0, i, '0);
            cycle();
        end
        idle(3);
    endtask

    initial begin
        cyc    = 0;
        n_chk  = 0;
        n_fail = 0;
        for (int i = 0; i < NI; i++) begin
            last[i][0] = '0;
            last[i][1] = '0;
        end
        test_reset();
        test_reset_mid();
        test_byte_enable();
        test_rdw_modes();
        test_collision();
        test_wrap();
        test_back_to_back();
        for (int k = 0; k < 2*NI; k++) begin
            n_chk++;
            if (sb[k].size() != 0) begin
                n_fail++;
                $display("FAIL drain inst%0d port%0d: %0d responses outstanding, required 0", k/2, k%2, sb[k].size());
            end
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_dp_be.md
Name: ram_dp_be

Overview:
- Parametrised true dual-port synchronous RAM. This is the next generation of the team's single-port RAM.
- Two independent read/write ports (A, B) with per-byte write enables.
- Selectable read-during-write mode and an optional output pipeline register.
- Per-port request/response-valid handshake with fixed latency. Used as shared data memory between core and DMA/debug paths.

Parameters:
- dat_width, 32, data word width. Must be a multiple of 8.
- adr_width, 32, address port width.
- mem_size, 1024, number of words. Must be a power of two.
- rdw_mode, 0, same-port read-during-write behaviour: 0 = READ_FIRST, 1 = WRITE_FIRST, 2 = NO_CHANGE.
- out_reg, 0, 1 adds an output register stage (read latency 2 instead of 1).

Ports:
- clk  in  1  clock, all logic on posedge.
- rst  in  1  asynchronous active-high reset.
- a_req_i  in  1  port A request strobe.
- a_we_i  in  1  port A write (1) / read (0), qualified by a_req_i.
- a_be_i  in  dat_width/8  port A byte enables; bit k enables bits [8k+7:8k].
- a_adr_i  in  adr_width  port A word address.
- a_dat_i  in  dat_width  port A write data.
- a_rvalid_o  out  1  port A response valid.
- a_dat_o  out  dat_width  port A read data.
- b_req_i, b_we_i, b_be_i, b_adr_i, b_dat_i, b_rvalid_o, b_dat_o  identical to port A, for port B.

Behaviour:
- Reset (async, active-high): all rvalid_o = 0, all dat_o = 0, pipeline stages cleared. Memory contents are not reset.
  - A request in flight when rst asserts is dropped; no rvalid for it after release.
- Addressing: only adr_i[log2(mem_size)-1:0] is used; upper bits are ignored, so addresses wrap modulo mem_size.
- Every accepted request (req_i = 1 at posedge) produces exactly one rvalid_o pulse, reads and writes alike.
  - Latency is 1 cycle (out_reg = 0) or 2 cycles (out_reg = 1).
  - Back-to-back requests are accepted every cycle; no stall and no backpressure.
- Write: bytes with be = 1 are updated at the posedge of the request; bytes with be = 0 are unchanged.
  - A write with be = 0 is a legal no-op write that still produces rvalid.
- Read: dat_o = mem[adr] sampled at the request edge.
- Same-port read-during-write (write request), rvalid still pulses in every mode; dat_o shows:
  - READ_FIRST: old word.
  - WRITE_FIRST: new merged word (old bytes where be = 0).
  - NO_CHANGE: dat_o holds its previous value.
- dat_o holds its value between responses; rvalid_o is a single-cycle pulse per request.
- Cross-port, same address, same cycle:
  - Both write: per byte, port A wins where both be bits are set; otherwise the enabled port's byte is written.
  - One writes, the other reads: the reader sees the old word, independent of rdw_mode.
- out_reg = 1: the stage-1 result (data plus valid) is registered once more; the data register loads only when the stage-1 valid is set.
- Invalid parameters (dat_width % 8 != 0, mem_size not a power of two) are flagged by an elaboration-time check.

Decomposition:
- Shared package ram_pkg holds:
  - RDW_READ_FIRST = 0, RDW_WRITE_FIRST = 1, RDW_NO_CHANGE = 2;
  - a clog2-based address-index width function;
  - a byte-merge function (old, new, be) -> merged word.
- One natural sub-module: ram_port_rsp. It contains the per-port rdw-mode data select, the valid pipeline and the optional output register, and is instantiated twice.
- The memory array and cross-port write arbitration stay in the top.

Test Plan:
- Reset mid-traffic: issue an A read and assert rst asynchronously before the next edge -> rvalid_o/dat_o go 0 immediately; no rvalid after release.
- Byte-enable merge: A writes 0xFFFFFFFF to addr 5, then writes 0x12345678 with be = 4'b0101; A reads addr 5 -> 0xFF34FF78 with rvalid exactly 1 cycle later (out_reg = 0).
- rdw_mode sweep: mem[7] = 0xAAAA0000; A writes 0x0000BBBB with be = 4'hF to addr 7 -> dat_o is:
  - 0xAAAA0000 for READ_FIRST;
  - 0x0000BBBB for WRITE_FIRST;
  - the prior dat_o for NO_CHANGE.
  - rvalid pulses in all three modes.
- Cross-port collision: same cycle, A writes 0x11111111 (be = 4'b0011) and B writes 0x22222222 (be = 4'b0110) to addr 3, initial 0 -> mem[3] = 0x00221111. In the same cycle a B read of addr 3 (separate run) returns 0.
- Address wrap with out_reg = 1, mem_size = 1024: write 0xDEADBEEF at addr 0x400, read addr 0 -> 0xDEADBEEF, rvalid 2 cycles after the request.
- Throughput: 16 back-to-back reads on both ports, addrs 0..15 preloaded with i*3 -> 16 consecutive rvalid pulses per port in order, data i*3.
